chess_clock_multi: RTL and testbench

//   N-player parametrised chess clock. Successor to the two-player chess_clock.

---
 rtl/chess_clock_multi.sv | 169 ++++++++++++++++
 tb/tb_chess_clock_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_multi.sv
// N-player chess clock with prescaled time base, move hand-off, saturating add-time and IDLE/RUN/PAUSED/FLAGGED control.
// Optional Fischer increment on each accepted move: define CHESS_CLOCK_INCREMENT_EN.
module chess_clock_multi #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 16,
  parameter int INIT_TIME = 300,
  parameter int TICK_DIV  = 100,
  parameter int ADD_STEP  = 10,
  parameter int INCREMENT = 5,
  localparam int IDX_W    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          pause_i,
  input  logic                          move_i,
  input  logic [N_PLAYERS-1:0]          add_time_i,
  output logic [N_PLAYERS*TIME_W-1:0]   player_time_o,
  output logic [N_PLAYERS-1:0]          player_flag_o,
  output logic [IDX_W-1:0]              active_o,
  output logic [1:0]                    state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TIME_W-1:0] MAX_T  = '1;
  localparam logic [TIME_W-1:0] INIT_T = TIME_W'(INIT_TIME);
  localparam logic [PW-1:0]     LAST_P = PW'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_A = IDX_W'(N_PLAYERS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    FLAGGED = 2'b11
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 active_q, active_d;
  logic [PW-1:0]                    presc_q, presc_d;
  logic [N_PLAYERS-1:0][TIME_W-1:0] time_q, time_d;
  logic [N_PLAYERS-1:0]             flag_q, flag_d;
  logic                             tick_s;
  logic                             flag_now_s;
  logic                             add_en_s;
  logic [TIME_W-1:0]                cur_t_s;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                input logic [31:0] step);
    logic [TIME_W+32:0] s;
    s = {33'b0, t} + {{(TIME_W + 1){1'b0}}, step};
    if (s > {33'b0, MAX_T}) begin
      return MAX_T;
    end else begin
      return s[TIME_W-1:0];
    end
  endfunction

`ifndef CHESS_CLOCK_INCREMENT_EN
  localparam logic [31:0] INC_UNUSED = 32'(INCREMENT);
  logic unused_inc_s;
  assign unused_inc_s = ^INC_UNUSED;
`endif

  // Next-state logic for the control FSM, prescaler, times and flags.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    presc_d    = presc_q;
    time_d     = time_q;
    flag_d     = flag_q;
    flag_now_s = 1'b0;
    tick_s     = (presc_q == LAST_P);
    cur_t_s    = time_q[active_q];
    add_en_s   = (state_q == IDLE) || (state_q == PAUSED);

    for (int i = 0; i < N_PLAYERS; i++) begin
      if (add_en_s && add_time_i[i]) begin
        time_d[i] = sat_add(time_q[i], 32'(ADD_STEP));
      end else begin
        time_d[i] = time_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          presc_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (pause_i) begin
          state_d = PAUSED;
        end else begin
          if (tick_s) begin
            presc_d = '0;
            if (cur_t_s != '0) begin
              time_d[active_q] = cur_t_s - TIME_W'(1);
              if (cur_t_s == TIME_W'(1)) begin
                flag_d[active_q] = 1'b1;
                state_d          = FLAGGED;
                flag_now_s       = 1'b1;
              end else begin
                state_d = RUN;
              end
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // Hand-off happens after this cycle's tick has been charged to the leaving player.
          if (move_i && !flag_now_s) begin
`ifdef CHESS_CLOCK_INCREMENT_EN
            time_d[active_q] = sat_add(time_d[active_q], 32'(INCREMENT));
`endif
            active_d = (active_q == LAST_A) ? '0 : active_q + IDX_W'(1);
            presc_d  = '0;
          end else begin
            active_d = active_q;
          end
        end
      end
      PAUSED: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (!pause_i) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      FLAGGED: begin
        state_d = FLAGGED;
        time_d  = time_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; async reset restores the initial game setup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      active_q <= '0;
      presc_q  <= '0;
      time_q   <= {N_PLAYERS{INIT_T}};
      flag_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      flag_q   <= flag_d;
    end
  end

  assign player_time_o = time_q;
  assign player_flag_o = flag_q;
  assign active_o      = active_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_chess_clock_multi.sv
// Scoreboard bench for chess_clock_multi: a rule-level model predicts each cycle, a monitor compares.
module tb_chess_clock_multi;
  localparam int N = 3, TW = 8, INIT = 5, DIV = 4, ADD = 10, INC = 2, IW = 2;
  localparam int MAXT = 255;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, move = 1'b0;
  logic [N-1:0]    add = '0;
  logic [N*TW-1:0] ptime;
  logic [N-1:0]    pflag;
  logic [IW-1:0]   act;
  logic [1:0]      st;

  chess_clock_multi #(.N_PLAYERS(N), .TIME_W(TW), .INIT_TIME(INIT), .TICK_DIV(DIV),
                      .ADD_STEP(ADD), .INCREMENT(INC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .move_i(move),
    .add_time_i(add), .player_time_o(ptime), .player_flag_o(pflag),
    .active_o(act), .state_o(st));

  always #5 clk = ~clk;

  typedef struct {
    logic [N*TW-1:0] pt;
    logic [N-1:0]    fl;
    logic [IW-1:0]   ac;
    logic [1:0]      st;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int m_time[N];
  bit m_flag[N];
  int m_act, m_st, m_elapsed;

  function automatic int min_max(input int v);
    return (v > MAXT) ? MAXT : v;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pt[i*TW +: TW] = TW'(m_time[i]);
      e.fl[i] = m_flag[i];
    end
    e.ac = IW'(m_act);
    e.st = 2'(m_st);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_time[i] = INIT;
      m_flag[i] = 1'b0;
    end
    m_act = 0; m_st = 0; m_elapsed = 0;
  endtask

  // States: 0 idle, 1 run, 2 paused, 3 flagged.
  task automatic model_step(input bit s, input bit p, input bit mv, input logic [N-1:0] a);
    int prev;
    bit flagged;
    prev = m_st;
    flagged = 1'b0;
    if (prev == 0 || prev == 2)
      for (int i = 0; i < N; i++)
        if (a[i]) m_time[i] = min_max(m_time[i] + ADD);
    case (prev)
      0: if (s) begin m_st = 1; m_elapsed = 0; end
      1: begin
        if (!s) m_st = 0;
        else if (p) m_st = 2;
        else begin
          m_elapsed++;
          if (m_elapsed == DIV) begin
            m_elapsed = 0;
            if (m_time[m_act] > 0) begin
              m_time[m_act]--;
              if (m_time[m_act] == 0) begin
                m_flag[m_act] = 1'b1; m_st = 3; flagged = 1'b1;
              end
            end
          end
          if (mv && !flagged) begin
`ifdef CHESS_CLOCK_INCREMENT_EN
            m_time[m_act] = min_max(m_time[m_act] + INC);
`endif
            m_act = (m_act + 1) % N;
            m_elapsed = 0;
          end
        end
      end
      2: begin
        if (!s) m_st = 0;
        else if (!p) m_st = 1;
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit s, input bit p, input bit mv, input logic [N-1:0] a);
    @(negedge clk);
    start = s; pause = p; move = mv; add = a;
    model_step(s, p, mv, a);
    q.push_back(snap());
    @(posedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_time"}, int'(ptime), int'({N{8'(INIT)}}));
    chk({tag, "_flag"}, int'(pflag), 0);
    chk({tag, "_active"}, int'(act), 0);
    chk({tag, "_state"}, int'(st), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; move = 1'b0; add = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each clocked cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ptime !== e.pt || pflag !== e.fl || act !== e.ac || st !== e.st) begin
          failures++;
          $display("FAIL cycle_outputs got time=%h flag=%b act=%0d st=%0d expected time=%h flag=%b act=%0d st=%0d",
                   ptime, pflag, act, st, e.pt, e.fl, e.ac, e.st);
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    do_reset();

    // T1: start and run 8 cycles: two ticks on player 0.
    repeat (9) step(1, 0, 0, '0);
    #2;
    chk("t1_p0", int'(ptime[7:0]), 3);
    chk("t1_state", int'(st), 1);

    // T2: four consecutive moves, active goes 1,2,0,1.
    repeat (4) step(1, 0, 1, '0);
    #2;
    chk("t2_active", int'(act), 1);

    // T3: pause, add to player 2, hold paused, then add during RUN.
    step(1, 1, 0, '0);
    repeat (3) step(1, 1, 0, 3'b100);
    repeat (20) step(1, 1, 0, '0);
    #2;
    chk("t3_state", int'(st), 2);
    step(1, 0, 0, '0);
    repeat (3) step(1, 0, 0, 3'b001);

    // T4: run player 1 down to zero.
    n = 0;
    while (m_st != 3 && n < 1000) begin
      step(1, 0, 0, '0);
      n++;
    end
    #2;
    chk("t4_state", int'(st), 3);
    chk("t4_flag", int'(pflag), 3'b010);
    chk("t4_p1", int'(ptime[15:8]), 0);
    repeat (15) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     N'($urandom_range(0, 7)));
    #2;
    chk("t4_frozen_flag", int'(pflag), 3'b010);

    // T5: saturating add in IDLE.
    do_reset();
    repeat (30) step(0, 0, 0, 3'b001);
    #2;
    chk("t5_p0_sat", int'(ptime[7:0]), 255);
    chk("t5_state", int'(st), 0);

    // T6: async reset between clock edges.
    do_reset();
    repeat (7) step(1, 0, 0, '0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset("t6_async");
    @(negedge clk);
    rst_n = 1'b1;

    // Random phase.
    for (int c = 0; c < 800; c++) begin
      if (m_st == 3 || $urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0);
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
